// File: rtl/utt_ctrl.sv
// utt_ctrl: utterance sequencer between the feature front-end and the decon
// recognition controller.
//   - COLLECT: stores coefficients into the cepstrum RAM at {frame, coef}.
//   - LAUNCH: starts recognition with frame_num, start and fv_ack.
//   - WAIT: waits for result_ack, guarded by a watchdog.
//   - REPORT / DRAIN: emits one report per utterance, then waits for the
//     decoder to drop result_ack.
// Ports:
//   clk, reset             clock, async active-low reset
//   fe_valid/data/last     front-end coefficient stream; fe_ready = accept
//   cep_wren/waddr/wdata   cepstrum RAM write port (registered)
//   frame_num, start,      launch interface to decon
//   fv_ack
//   result_ack, result,    decoder completion
//   overflow
//   rec_valid/word/ovf/err recognition report (one pulse per utterance)
//   frm_overrun            sticky: more than 256 frames offered
module utt_ctrl #(
    parameter int unsigned NCOEF   = 26,
    parameter int unsigned DATA_W  = 16,
    parameter logic [23:0] TIMEOUT = 24'hFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fe_valid,
    input  logic [DATA_W-1:0] fe_data,
    input  logic              fe_last,
    output logic              fe_ready,
    output logic              cep_wren,
    output logic [12:0]       cep_waddr,
    output logic [DATA_W-1:0] cep_wdata,
    output logic [7:0]        frame_num,
    output logic              start,
    output logic              fv_ack,
    input  logic              result_ack,
    input  logic [5:0]        result,
    input  logic              overflow,
    output logic              rec_valid,
    output logic [5:0]        rec_word,
    output logic              rec_ovf,
    output logic              rec_err,
    output logic              frm_overrun
);

    typedef enum logic [2:0] {COLLECT, LAUNCH, WAIT, REPORT, DRAIN} state_t;

    localparam logic [4:0]  LAST_COEF = 5'(NCOEF - 1);
    localparam logic [23:0] WD_LAST   = TIMEOUT - 24'd1;

    state_t              state_q, state_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [4:0]          coef_cnt_q, coef_cnt_d;
    logic [23:0]         wd_q, wd_d;
    logic                ovr_q, ovr_d;
    logic                cep_wren_q, cep_wren_d;
    logic [12:0]         cep_waddr_q, cep_waddr_d;
    logic [DATA_W-1:0]   cep_wdata_q, cep_wdata_d;
    logic [7:0]          frame_num_q, frame_num_d;
    logic                start_q, start_d;
    logic                fv_ack_q, fv_ack_d;
    logic                rec_valid_q, rec_valid_d;
    logic [5:0]          rec_word_q, rec_word_d;
    logic                rec_ovf_q, rec_ovf_d;
    logic                rec_err_q, rec_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            frame_cnt_q <= '0;
            coef_cnt_q  <= '0;
            wd_q        <= '0;
            ovr_q       <= 1'b0;
            cep_wren_q  <= 1'b0;
            cep_waddr_q <= '0;
            cep_wdata_q <= '0;
            frame_num_q <= '0;
            start_q     <= 1'b0;
            fv_ack_q    <= 1'b0;
            rec_valid_q <= 1'b0;
            rec_word_q  <= '0;
            rec_ovf_q   <= 1'b0;
            rec_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            coef_cnt_q  <= coef_cnt_d;
            wd_q        <= wd_d;
            ovr_q       <= ovr_d;
            cep_wren_q  <= cep_wren_d;
            cep_waddr_q <= cep_waddr_d;
            cep_wdata_q <= cep_wdata_d;
            frame_num_q <= frame_num_d;
            start_q     <= start_d;
            fv_ack_q    <= fv_ack_d;
            rec_valid_q <= rec_valid_d;
            rec_word_q  <= rec_word_d;
            rec_ovf_q   <= rec_ovf_d;
            rec_err_q   <= rec_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        coef_cnt_d  = coef_cnt_q;
        wd_d        = wd_q;
        ovr_d       = ovr_q;
        cep_wren_d  = 1'b0;
        cep_waddr_d = cep_waddr_q;
        cep_wdata_d = cep_wdata_q;
        frame_num_d = frame_num_q;
        start_d     = start_q;
        fv_ack_d    = 1'b0;
        rec_valid_d = 1'b0;
        rec_word_d  = rec_word_q;
        rec_ovf_d   = rec_ovf_q;
        rec_err_d   = rec_err_q;

        unique case (state_q)
            COLLECT: begin
                if (fe_valid) begin
                    // Past the frame limit, transfers are swallowed unwritten.
                    if (!ovr_q) begin
                        cep_wren_d  = 1'b1;
                        cep_waddr_d = {frame_cnt_q, coef_cnt_q};
                        cep_wdata_d = fe_data;
                    end
                    if (coef_cnt_q == LAST_COEF) begin
                        coef_cnt_d = '0;
                        if (!ovr_q) begin
                            // Frame 255 is the last one that fits; frame_cnt
                            // parks there once it completes.
                            if (frame_cnt_q == 8'hFF) begin
                                if (!fe_last) ovr_d = 1'b1;
                            end else begin
                                frame_cnt_d = frame_cnt_q + 8'd1;
                            end
                        end
                    end else begin
                        coef_cnt_d = coef_cnt_q + 5'd1;
                    end
                    if (fe_last) begin
                        if (ovr_q) begin
                            frame_num_d = 8'hFF;
                            state_d     = LAUNCH;
                        end else if (coef_cnt_q == LAST_COEF) begin
                            frame_num_d = frame_cnt_q;
                            state_d     = LAUNCH;
                        end else if (frame_cnt_q == 8'd0) begin
                            // No complete frame: report an error, skip decon.
                            rec_word_d = '0;
                            rec_ovf_d  = 1'b0;
                            rec_err_d  = 1'b1;
                            state_d    = REPORT;
                        end else begin
                            // Partial trailing frame is dropped.
                            frame_num_d = frame_cnt_q - 8'd1;
                            state_d     = LAUNCH;
                        end
                    end
                end
            end
            LAUNCH: begin
                start_d  = 1'b1;
                fv_ack_d = 1'b1;
                wd_d     = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                // result_ack has priority over an expiring watchdog.
                if (result_ack) begin
                    rec_word_d = result;
                    rec_ovf_d  = overflow;
                    rec_err_d  = 1'b0;
                    start_d    = 1'b0;
                    state_d    = REPORT;
                end else if (wd_q == WD_LAST) begin
                    rec_word_d = '0;
                    rec_ovf_d  = 1'b0;
                    rec_err_d  = 1'b1;
                    start_d    = 1'b0;
                    state_d    = REPORT;
                end else begin
                    wd_d = wd_q + 24'd1;
                end
            end
            REPORT: begin
                rec_valid_d = 1'b1;
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (!result_ack) begin
                    frame_cnt_d = '0;
                    coef_cnt_d  = '0;
                    ovr_d       = 1'b0;
                    state_d     = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign fe_ready    = (state_q == COLLECT);
    assign cep_wren    = cep_wren_q;
    assign cep_waddr   = cep_waddr_q;
    assign cep_wdata   = cep_wdata_q;
    assign frame_num   = frame_num_q;
    assign start       = start_q;
    assign fv_ack      = fv_ack_q;
    assign rec_valid   = rec_valid_q;
    assign rec_word    = rec_word_q;
    assign rec_ovf     = rec_ovf_q;
    assign rec_err     = rec_err_q;
    assign frm_overrun = ovr_q;

endmodule

// File: tb/tb_utt_ctrl.sv
// Directed-sequence bench for utt_ctrl with randomized coefficient data and
// valid gaps. Expected RAM writes and frame counts come from the utterance
// length using plain arithmetic on the {frame, coef} addressing rule.
module tb_utt_ctrl;
    localparam int NCOEF = 26;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fe_valid = 1'b0;
    logic [DW-1:0] fe_data = '0;
    logic          fe_last = 1'b0;
    logic          result_ack = 1'b0;
    logic [5:0]    result = '0;
    logic          overflow = 1'b0;
    logic          fe_ready, cep_wren, start, fv_ack, rec_valid, rec_ovf, rec_err, frm_overrun;
    logic [12:0]   cep_waddr;
    logic [DW-1:0] cep_wdata;
    logic [7:0]    frame_num;
    logic [5:0]    rec_word;

    int n_pass = 0;
    int n_chk  = 0;
    int fv_cnt = 0;
    int rv_cnt = 0;
    logic [28:0] got_wr[$];
    logic [28:0] exp_wr[$];

    utt_ctrl #(.NCOEF(NCOEF), .DATA_W(DW), .TIMEOUT(24'd16)) dut (
        .clk(clk), .reset(reset),
        .fe_valid(fe_valid), .fe_data(fe_data), .fe_last(fe_last), .fe_ready(fe_ready),
        .cep_wren(cep_wren), .cep_waddr(cep_waddr), .cep_wdata(cep_wdata),
        .frame_num(frame_num), .start(start), .fv_ack(fv_ack),
        .result_ack(result_ack), .result(result), .overflow(overflow),
        .rec_valid(rec_valid), .rec_word(rec_word), .rec_ovf(rec_ovf), .rec_err(rec_err),
        .frm_overrun(frm_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cep_wren) got_wr.push_back({cep_waddr, cep_wdata});
        if (fv_ack) fv_cnt++;
        if (rec_valid) rv_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Complete frames that the launch covers (0 means empty utterance).
    function automatic int exp_frames(input int n);
        int f;
        f = n / NCOEF;
        if (f > 256) f = 256;
        return f;
    endfunction

    task automatic send(input int n);
        got_wr.delete();
        exp_wr.delete();
        fv_cnt = 0;
        rv_cnt = 0;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                fe_valid = 1'b0;
                tick;
            end
            fe_valid = 1'b1;
            fe_data  = DW'($urandom);
            fe_last  = (k == n - 1);
            if (k / NCOEF < 256)
                exp_wr.push_back({13'(((k / NCOEF) << 5) | (k % NCOEF)), fe_data});
            tick;
        end
        fe_valid = 1'b0;
        fe_last  = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int bad;
        bad = 0;
        if (got_wr.size() == exp_wr.size())
            foreach (exp_wr[i]) if (got_wr[i] !== exp_wr[i]) bad++;
        chk({tag, "_wcnt"}, got_wr.size(), exp_wr.size());
        chk({tag, "_wbad"}, bad, 0);
    endtask

    task automatic expect_launch(input string tag, input int n);
        chk({tag, "_pre_start"}, 32'(start), 0);
        chk({tag, "_busy"}, 32'(fe_ready), 0);
        tick;
        chk({tag, "_fv_ack"}, 32'(fv_ack), 1);
        chk({tag, "_start"}, 32'(start), 1);
        chk({tag, "_frame_num"}, 32'(frame_num), exp_frames(n) - 1);
        tick;
        chk({tag, "_fv_pulse"}, 32'(fv_ack), 0);
        chk({tag, "_start_hold"}, 32'(start), 1);
        chk({tag, "_fv_cnt"}, fv_cnt, 1);
    endtask

    task automatic respond(input string tag, input logic [5:0] r, input logic o, input int hold);
        result = r;
        overflow = o;
        result_ack = 1'b1;
        tick;
        chk({tag, "_start_fall"}, 32'(start), 0);
        chk({tag, "_rec_word"}, 32'(rec_word), 32'(r));
        chk({tag, "_rec_ovf"}, 32'(rec_ovf), 32'(o));
        chk({tag, "_rec_err"}, 32'(rec_err), 0);
        chk({tag, "_rv_early"}, 32'(rec_valid), 0);
        if (hold == 0) result_ack = 1'b0;
        tick;
        chk({tag, "_rec_valid"}, 32'(rec_valid), 1);
        chk({tag, "_busy_rep"}, 32'(fe_ready), 0);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, "_holdoff"}, 32'(fe_ready), 0);
        end
        result_ack = 1'b0;
        tick;
        chk({tag, "_back"}, 32'(fe_ready), 1);
        chk({tag, "_rv_cnt"}, rv_cnt, 1);
    endtask

    initial begin
        int cnt;
        logic [5:0] r;

        // Reset state
        #2;
        chk("rst_fe_ready", 32'(fe_ready), 1);
        chk("rst_outs", 32'({cep_wren, start, fv_ack, rec_valid, rec_ovf, rec_err, frm_overrun}), 0);
        chk("rst_bus", 32'({cep_waddr, frame_num, rec_word}), 0);
        chk("rst_wdata", 32'(cep_wdata), 0);
        tick; tick;
        reset = 1'b1;
        tick;

        // Normal 3-frame utterance
        send(78);
        expect_launch("n3", 78);
        check_writes("n3");
        respond("n3", 6'd17, 1'b1, 0);

        // Partial trailing frame
        send(40);
        expect_launch("part", 40);
        check_writes("part");
        r = 6'($urandom_range(1, 63));
        respond("part", r, 1'b0, 0);

        // Empty utterance: fe_last inside the first frame
        send(10);
        chk("empty_err_early", 32'(rec_err), 1);
        chk("empty_rv_early", 32'(rec_valid), 0);
        tick;
        chk("empty_rec_valid", 32'(rec_valid), 1);
        chk("empty_rec_err", 32'(rec_err), 1);
        chk("empty_rec_word", 32'(rec_word), 0);
        check_writes("empty");
        tick;
        chk("empty_rv_pulse", 32'(rec_valid), 0);
        tick;
        chk("empty_back", 32'(fe_ready), 1);
        chk("empty_no_launch", fv_cnt, 0);

        // Overrun: 257 frames plus one more coefficient
        send(257 * NCOEF + 1);
        chk("ovr_flag", 32'(frm_overrun), 1);
        expect_launch("ovr", 257 * NCOEF + 1);
        check_writes("ovr");
        respond("ovr", 6'd42, 1'b0, 0);
        chk("ovr_cleared", 32'(frm_overrun), 0);

        // Watchdog timeout
        send(52);
        expect_launch("to", 52);
        cnt = 1;
        while (start && cnt < 64) begin
            tick;
            cnt++;
        end
        chk("to_cycles", cnt, 16);
        chk("to_rec_err", 32'(rec_err), 1);
        chk("to_rec_word", 32'(rec_word), 0);
        tick;
        chk("to_rec_valid", 32'(rec_valid), 1);
        tick;
        chk("to_back", 32'(fe_ready), 1);

        // result_ack on the terminal watchdog cycle, then hold-off in DRAIN
        send(26);
        expect_launch("term", 26);
        for (int i = 0; i < 14; i++) tick;
        respond("term", 6'd33, 1'b1, 5);

        // Reset mid-WAIT
        send(60);
        expect_launch("rw", 60);
        tick; tick;
        reset = 1'b0;
        #1;
        chk("rw_fe_ready", 32'(fe_ready), 1);
        chk("rw_outs", 32'({cep_wren, start, fv_ack, rec_valid, rec_ovf, rec_err, frm_overrun}), 0);
        chk("rw_bus", 32'({cep_waddr, frame_num, rec_word}), 0);
        chk("rw_wdata", 32'(cep_wdata), 0);
        tick;
        chk("rw_no_report", rv_cnt, 0);
        reset = 1'b1;
        tick;
        send(26);
        expect_launch("rw2", 26);
        check_writes("rw2");
        respond("rw2", 6'd5, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
